// File: rtl/ssd1963_bus_writer.sv
// One SSD1963 8080-bus write transaction: a command byte followed by a repeated data word.
// Pin registers are loaded from the FSM state, so every pin follows its state by one cycle.
module ssd1963_bus_writer #(
    parameter int DW       = 16,
    parameter int CNTW     = 20,
    parameter int CS_SETUP = 1,
    parameter int WR_LOW   = 2,
    parameter int WR_HIGH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            task_start,
    input  logic [7:0]      task_cmd,
    input  logic [DW-1:0]   task_word,
    input  logic [CNTW-1:0] task_count,
    output logic            task_done,
    output logic            busy,
    output logic            lcd_cs_n,
    output logic            lcd_dc,
    output logic            lcd_wr_n,
    output logic            lcd_rd_n,
    output logic [DW-1:0]   lcd_d
);

    localparam int TW = 16;
    localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] T_LO    = TW'(WR_LOW - 1);
    localparam logic [TW-1:0] T_HI    = TW'(WR_HIGH - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, CMD_LO, CMD_HI, DAT_LO, DAT_HI, HOLD, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [DW-1:0]   word_q, word_d;

    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            cs_n_q, cs_n_d;
    logic            dc_q, dc_d;
    logic            wr_n_q, wr_n_d;
    logic [DW-1:0]   d_q, d_d;
    logic            tmr_last;

    assign tmr_last = (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        word_d  = word_q;
        dc_d    = dc_q;
        d_d     = d_q;
        busy_d  = (state_q != IDLE);
        done_d  = (state_q == DONE);
        cs_n_d  = (state_q == IDLE) || (state_q == DONE);
        wr_n_d  = !((state_q == CMD_LO) || (state_q == DAT_LO));

        case (state_q)
            IDLE: begin
                // busy_q still high here means task_done is on the pins; refuse that start
                if (task_start && !busy_q) begin
                    cmd_d   = task_cmd;
                    word_d  = task_word;
                    cnt_d   = task_count;
                    tmr_d   = T_SETUP;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dc_d = 1'b0;
                d_d  = DW'(cmd_q);
                if (tmr_last) begin
                    tmr_d   = T_LO;
                    state_d = CMD_LO;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            CMD_LO: begin
                if (tmr_last) begin
                    tmr_d   = T_HI;
                    state_d = CMD_HI;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            CMD_HI: begin
                if (tmr_last) begin
                    if (cnt_q != '0) begin
                        // data phase set up while wr_n is still high
                        dc_d    = 1'b1;
                        d_d     = word_q;
                        rem_d   = cnt_q;
                        tmr_d   = T_LO;
                        state_d = DAT_LO;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DAT_LO: begin
                if (tmr_last) begin
                    tmr_d   = T_HI;
                    state_d = DAT_HI;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DAT_HI: begin
                if (tmr_last) begin
                    rem_d = rem_q - CNTW'(1);
                    if (rem_q == CNTW'(1)) begin
                        state_d = HOLD;
                    end else begin
                        tmr_d   = T_LO;
                        state_d = DAT_LO;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                dc_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b1;
            wr_n_q  <= 1'b1;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            word_q  <= word_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            wr_n_q  <= wr_n_d;
            d_q     <= d_d;
        end
    end

    assign task_done = done_q;
    assign busy      = busy_q;
    assign lcd_cs_n  = cs_n_q;
    assign lcd_dc    = dc_q;
    assign lcd_wr_n  = wr_n_q;
    assign lcd_rd_n  = 1'b1;
    assign lcd_d     = d_q;

endmodule
